vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Consumes the 25 MHz divided pixel clock and produces 640x480@60 VGA timing: hsync, vsync, video_on and pixel coordinates for the game renderer.
- Runs entirely on the 100 MHz system clock. The divided clock is treated as a same-domain level, and its rising edges become a one-cycle pixel strobe.
- Sits directly downstream of the clock divider and upstream of the sprite/colour logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- CNT_W, 10, coordinate width; must satisfy H_TOTAL <= 2^CNT_W and V_TOTAL <= 2^CNT_W

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  reset, asynchronous, active-low
- pix_clk_in  in  1  divided pixel clock; must be a register output clocked by clk
- pix_tick  out  1  one-clk pulse, coincident with each coordinate update
- pixel_x  out  CNT_W  horizontal count, 0..H_TOTAL-1
- pixel_y  out  CNT_W  vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
- frame_start  out  1  one-clk pulse when outputs show (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Edge detect:
  - Register pix_clk_in into prev; prev resets to 1.
  - Internal strobe = pix_clk_in & ~prev.
  - Exactly one strobe per rising edge, regardless of high-time.
  - Because prev resets to 1, pix_clk_in high at reset release produces no strobe.
- On the clk edge where strobe is true:
  - pixel_x increments; at H_TOTAL-1 it wraps to 0 and pixel_y increments.
  - pixel_y wraps from V_TOTAL-1 to 0 when pixel_x wraps.
- All outputs are registered and change on the same clk edge, decoded from the new counter values:
  - hsync = SYNC_POL while pixel_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751]; otherwise ~SYNC_POL.
  - vsync = SYNC_POL while pixel_y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491]; otherwise ~SYNC_POL.
  - video_on as defined under Ports.
  - frame_start = 1 iff the new position is (0,0).
  - pix_tick = registered strobe (high in the cycle the new values appear).
- Latency: a rising transition of pix_clk_in (after clk edge k) gives updated outputs after clk edge k+1.
- Cycles without a strobe: all counters and sync outputs hold; pix_tick and frame_start are 0.
- Reset values:
  - pixel_x = H_TOTAL-1 (799), pixel_y = V_TOTAL-1 (524).
  - hsync = vsync = ~SYNC_POL, video_on = 0, pix_tick = 0, frame_start = 0.
  - These values are self-consistent, so the first strobe after reset lands on (0,0) with frame_start = 1.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously); no partial-line recovery.
- pix_clk_in stuck at either level: timing freezes at the current position, with no glitches on any output.
- Minimum strobe spacing is 2 clk (edge-detect inherent); the nominal divider supplies one strobe every 4 clk.

Decomposition:
- Package vga_timing_pkg:
  - 640x480 constants (active, porches, sync widths, totals).
  - SYNC_POL default.
  - CNT_W.
- Sub-module sync_axis_gen, instantiated once per axis:
  - Parameters: ACTIVE, FP, SYNC, BP, SYNC_POL, CNT_W.
  - Inputs: clk, rst_n, en.
  - Outputs: count, wrap, sync, active.
  - Horizontal instance: en = strobe.
  - Vertical instance: en = strobe & h_wrap.
- Top level holds the edge detector plus frame_start and pix_tick registers.

Test Plan:
- Reset, then pix_clk_in toggling every 2 clk -> first pix_tick shows (0,0), video_on = 1, frame_start = 1 for exactly 1 clk, hsync = vsync = 1.
- Run one line -> hsync low exactly for pixel_x 656..751 (96 ticks); video_on falls at pixel_x 640; line length 800 ticks = 3200 clk.
- Run two frames -> vsync low exactly for pixel_y 490..491 (1600 ticks); frame_start period 420000 ticks = 1,680,000 clk; pixel_y wraps 524 -> 0.
- Hold pix_clk_in high 10 clk, then low 20 clk -> exactly one pix_tick, then outputs frozen. Release rst_n with pix_clk_in = 1 -> no tick until its next rising edge.
- Assert rst_n = 0 mid-clock-cycle at position (300,200) -> outputs immediately become 799/524, video_on = 0, syncs inactive, pix_tick = 0.
- Rebuild with SYNC_POL = 1 -> hsync and vsync pulses go high over the same ranges; idle level is 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the VGA sync generator and its axis counters.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam bit SYNC_POL = 1'b0;
  localparam int CNT_W    = 10;

endpackage

// File: rtl/sync_axis_gen.sv
// One timing axis: wrapping position counter with registered sync pulse, plus
// the active-region flag for the next position so the top can register video_on.
module sync_axis_gen #(
  parameter int ACTIVE   = 640,
  parameter int FP       = 16,
  parameter int SYNC     = 96,
  parameter int BP       = 48,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o,
  output logic             sync_o,
  output logic             active_d_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_q, sync_d;

  // wrap_o flags that the next enable takes the counter back to zero
  assign wrap_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
    sync_d     = ((count_d >= SYNC_START) && (count_d <= SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    active_d_o = (count_d < ACT_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LAST;
      sync_q  <= ~SYNC_POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o = count_q;
  assign sync_o  = sync_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator on the system clock: edge-detects the divided pixel clock
// and advances horizontal/vertical counters once per pixel strobe.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP,
  parameter bit P_SYNC_POL = SYNC_POL,
  parameter int P_CNT_W    = CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_clk_in,
  output logic               pix_tick,
  output logic [P_CNT_W-1:0] pixel_x,
  output logic [P_CNT_W-1:0] pixel_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_start
);

  logic prev_q;
  logic strobe;
  logic h_wrap, v_wrap;
  logic h_act_d, v_act_d;
  logic pix_tick_q, frame_start_q, video_on_q;

  // prev resets high so a level already high at reset release is not an edge
  assign strobe = pix_clk_in & ~prev_q;

  sync_axis_gen #(
    .ACTIVE(P_H_ACTIVE), .FP(P_H_FP), .SYNC(P_H_SYNC), .BP(P_H_BP),
    .SYNC_POL(P_SYNC_POL), .CNT_W(P_CNT_W)
  ) u_h_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (strobe),
    .count_o    (pixel_x),
    .wrap_o     (h_wrap),
    .sync_o     (hsync),
    .active_d_o (h_act_d)
  );

  sync_axis_gen #(
    .ACTIVE(P_V_ACTIVE), .FP(P_V_FP), .SYNC(P_V_SYNC), .BP(P_V_BP),
    .SYNC_POL(P_SYNC_POL), .CNT_W(P_CNT_W)
  ) u_v_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (strobe & h_wrap),
    .count_o    (pixel_y),
    .wrap_o     (v_wrap),
    .sync_o     (vsync),
    .active_d_o (v_act_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q        <= 1'b1;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
      video_on_q    <= 1'b0;
    end else begin
      prev_q        <= pix_clk_in;
      pix_tick_q    <= strobe;
      frame_start_q <= strobe & h_wrap & v_wrap;
      if (strobe) begin
        video_on_q <= h_act_d & v_act_d;
      end
    end
  end

  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;
  assign video_on    = video_on_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Checks a default 640x480 instance and a shrunken active-high-sync instance against a tick-count position model.
module tb_vga_sync_gen;

  localparam int HA0 = 640, HF0 = 16, HS0 = 96, HB0 = 48;
  localparam int VA0 = 480, VF0 = 10, VS0 = 2,  VB0 = 33;
  localparam int HA1 = 8,   HF1 = 2,  HS1 = 3,  HB1 = 2;
  localparam int VA1 = 5,   VF1 = 1,  VS1 = 2,  VB1 = 1;
  localparam int HT0 = HA0 + HF0 + HS0 + HB0, VT0 = VA0 + VF0 + VS0 + VB0;
  localparam int HT1 = HA1 + HF1 + HS1 + HB1, VT1 = VA1 + VF1 + VS1 + VB1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_clk_in;
  logic       tick0, hs0, vs0, von0, fs0;
  logic       tick1, hs1, vs1, von1, fs1;
  logic [9:0] x0, y0, x1, y1;

  int   tests = 0;
  int   fails = 0;
  int   n = 0;          // pixel strobes since last reset
  bit   prev_m = 1'b1;
  bit   tick_e = 1'b0;
  int   hs_line0 = 0;
  int   vs_frame0 = 0;
  int   fs_small = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut0 (
    .clk(clk), .rst_n(rst_n), .pix_clk_in(pix_clk_in), .pix_tick(tick0),
    .pixel_x(x0), .pixel_y(y0), .hsync(hs0), .vsync(vs0),
    .video_on(von0), .frame_start(fs0)
  );

  vga_sync_gen #(
    .P_H_ACTIVE(HA1), .P_H_FP(HF1), .P_H_SYNC(HS1), .P_H_BP(HB1),
    .P_V_ACTIVE(VA1), .P_V_FP(VF1), .P_V_SYNC(VS1), .P_V_BP(VB1),
    .P_SYNC_POL(1'b1), .P_CNT_W(10)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_clk_in(pix_clk_in), .pix_tick(tick1),
    .pixel_x(x1), .pixel_y(y1), .hsync(hs1), .vsync(vs1),
    .video_on(von1), .frame_start(fs1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d (strobes=%0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic in_pulse(int c, int a, int fp, int s);
    return (c >= a + fp) && (c <= a + fp + s - 1);
  endfunction

  // Position after n strobes: reset parks at the last pixel of the frame.
  task automatic chk_all();
    int p0, p1, ex0, ey0, ex1, ey1;
    p0 = (n + HT0 * VT0 - 1) % (HT0 * VT0);
    p1 = (n + HT1 * VT1 - 1) % (HT1 * VT1);
    ex0 = p0 % HT0; ey0 = p0 / HT0;
    ex1 = p1 % HT1; ey1 = p1 / HT1;
    chk("x0", x0, ex0);
    chk("y0", y0, ey0);
    chk("hsync0", hs0, in_pulse(ex0, HA0, HF0, HS0) ? 0 : 1);
    chk("vsync0", vs0, in_pulse(ey0, VA0, VF0, VS0) ? 0 : 1);
    chk("video_on0", von0, (ex0 < HA0 && ey0 < VA0) ? 1 : 0);
    chk("frame_start0", fs0, (tick_e && p0 == 0) ? 1 : 0);
    chk("pix_tick0", tick0, tick_e);
    chk("x1", x1, ex1);
    chk("y1", y1, ey1);
    chk("hsync1", hs1, in_pulse(ex1, HA1, HF1, HS1) ? 1 : 0);
    chk("vsync1", vs1, in_pulse(ey1, VA1, VF1, VS1) ? 1 : 0);
    chk("video_on1", von1, (ex1 < HA1 && ey1 < VA1) ? 1 : 0);
    chk("frame_start1", fs1, (tick_e && p1 == 0) ? 1 : 0);
    chk("pix_tick1", tick1, tick_e);
  endtask

  // Drive one clk cycle of pix_clk_in, then check the registered outputs.
  task automatic step(input bit lvl);
    bit rise;
    pix_clk_in = lvl;
    rise = lvl && !prev_m;
    prev_m = lvl;
    @(posedge clk);
    #1;
    if (rise) n++;
    tick_e = rise;
    chk_all();
    if (tick0 && y0 == 0 && hs0 == 1'b0) hs_line0++;
    if (tick1 && n <= HT1 * VT1 && vs1 == 1'b1) vs_frame0++;
    if (fs1) fs_small++;
  endtask

  initial begin
    rst_n = 1'b0;
    pix_clk_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all();
    rst_n = 1'b1;
    prev_m = 1'b1;

    // nominal-rate toggling, 2 clk high / 2 clk low
    for (int i = 0; i < 12; i++) begin
      step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    end

    // random high/low times, enough strobes for a full default line and several small frames
    for (int i = 0; i < 12000 && n < 1000; i++) begin
      int hi, lo;
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 3);
      for (int k = 0; k < hi; k++) step(1'b1);
      for (int k = 0; k < lo; k++) step(1'b0);
    end
    chk("random_strobes_reached", (n >= 1000) ? 1 : 0, 1);
    chk("hsync_ticks_line0", hs_line0, HS0);
    chk("vsync_ticks_small_frame0", vs_frame0, VS1 * HT1);
    chk("frame_starts_small", fs_small, (n - 1) / (HT1 * VT1) + 1);

    // stuck high then stuck low: one strobe only, then frozen
    for (int k = 0; k < 10; k++) step(1'b1);
    for (int k = 0; k < 20; k++) step(1'b0);

    // asynchronous reset in the middle of a clk cycle
    for (int k = 0; k < 3; k++) step(1'b1);
    @(negedge clk);
    pix_clk_in = 1'b1;
    rst_n = 1'b0;
    #1;
    n = 0;
    tick_e = 1'b0;
    prev_m = 1'b1;
    chk_all();

    // release with pix_clk_in already high: no strobe until the next rising edge
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
